// File: rtl/tick_ctrl.sv
// tick_ctrl: synchronised, debounced run/step buttons gate a prescaled clk_en tick for gray_Nbits.
// Optional macro TICK_CTRL_AUTORUN_EN: leave reset already in RUN (free-running demo behaviour).
module tick_ctrl #(
    parameter int DIV       = 4,
    parameter int DB_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_run,
    input  logic btn_step,
    output logic clk_en,
    output logic running
);
    // state | meaning
    // PAUSE | idle, prescaler frozen, waiting for a run or step press
    // RUN   | prescaler counting, one tick per wrap
    // STEP  | single-cycle state, one tick issued on leaving it

    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
    localparam int B_RUN  = 0;
    localparam int B_STEP = 1;

    typedef enum logic [1:0] {
        S_PAUSE = 2'd0,
        S_RUN   = 2'd1,
        S_STEP  = 2'd2
    } state_t;

`ifdef TICK_CTRL_AUTORUN_EN
    localparam state_t RST_STATE   = S_RUN;
    localparam logic   RST_RUNNING = 1'b1;
`else
    localparam state_t RST_STATE   = S_PAUSE;
    localparam logic   RST_RUNNING = 1'b0;
`endif

    logic [1:0]     r_sync1;
    logic [1:0]     r_sync2;
    logic [1:0]     r_level;
    logic [1:0]     r_level_q;
    logic [1:0]     r_press;
    logic [DBW-1:0] r_db_cnt [2];
    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic           w_wrap;

    assign w_wrap = (r_cnt == CNT_LAST);

    // Press pulse is taken from the registered debounced level, so it lags the level by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_level   <= '0;
            r_level_q <= '0;
            r_press   <= '0;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1   <= {btn_step, btn_run};
            r_sync2   <= r_sync1;
            r_level_q <= r_level;
            r_press   <= r_level & ~r_level_q;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_level[i]  <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RST_STATE;
            r_cnt   <= '0;
            clk_en  <= 1'b0;
            running <= RST_RUNNING;
        end else begin
            clk_en  <= 1'b0;
            running <= (r_state == S_RUN);
            case (r_state)
                S_PAUSE: begin
                    if (r_press[B_RUN]) begin
                        r_state <= S_RUN;
                    end else if (r_press[B_STEP]) begin
                        r_state <= S_STEP;
                    end
                end
                S_RUN: begin
                    r_cnt  <= w_wrap ? '0 : r_cnt + CW'(1);
                    clk_en <= w_wrap;
                    if (r_press[B_RUN]) begin
                        r_state <= S_PAUSE;
                    end
                end
                S_STEP: begin
                    clk_en  <= 1'b1;
                    r_state <= S_PAUSE;
                end
                default: r_state <= S_PAUSE;
            endcase
        end
    end

endmodule

// File: tb/tb_tick_ctrl.sv
// Directed bench for tick_ctrl with DIV=4, DB_CYCLES=3; edge 0 is the first edge after reset release.
module tb_tick_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_run = 1'b0;
    logic btn_step = 1'b0;
    logic clk_en;
    logic running;
    int checks = 0;
    int failures = 0;

    tick_ctrl #(.DIV(4), .DB_CYCLES(3)) dut (
        .clk(clk),
        .rst(rst),
        .btn_run(btn_run),
        .btn_step(btn_step),
        .clk_en(clk_en),
        .running(running)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        btn_run = 1'b0;
        btn_step = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

`ifndef TICK_CTRL_AUTORUN_EN
    task automatic test_reset();
        do_reset();
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (clk_en !== 1'b0) begin
                failures++;
                $display("FAIL reset clk_en edge %0d: got %b expected 0", e, clk_en);
            end
            checks++;
            if (running !== 1'b0) begin
                failures++;
                $display("FAIL reset running edge %0d: got %b expected 0", e, running);
            end
        end
    endtask

    task automatic test_run_hold();
        logic exp_en, exp_run;
        do_reset();
        for (int e = 0; e < 30; e++) begin
            btn_run = (e <= 7);
            @(posedge clk);
            #1;
            exp_en  = (e >= 10) && ((e - 10) % 4 == 0);
            exp_run = (e >= 7);
            checks++;
            if (clk_en !== exp_en) begin
                failures++;
                $display("FAIL run_hold clk_en edge %0d: got %b expected %b", e, clk_en, exp_en);
            end
            checks++;
            if (running !== exp_run) begin
                failures++;
                $display("FAIL run_hold running edge %0d: got %b expected %b", e, running, exp_run);
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int e = 0; e < 20; e++) begin
            btn_run = (e < 2);
            @(posedge clk);
            #1;
            checks++;
            if (clk_en !== 1'b0 || running !== 1'b0) begin
                failures++;
                $display("FAIL glitch edge %0d: got clk_en=%b running=%b expected 0 0", e, clk_en, running);
            end
        end
    endtask

    task automatic test_step();
        logic exp_en, exp_run;
        do_reset();
        for (int e = 0; e < 53; e++) begin
            btn_step = (e <= 3) || (e >= 20 && e <= 23);
            btn_run  = (e >= 40 && e <= 43);
            @(posedge clk);
            #1;
            exp_en  = (e == 7) || (e == 27) || (e == 50);
            exp_run = (e >= 47);
            checks++;
            if (clk_en !== exp_en) begin
                failures++;
                $display("FAIL step clk_en edge %0d: got %b expected %b", e, clk_en, exp_en);
            end
            checks++;
            if (running !== exp_run) begin
                failures++;
                $display("FAIL step running edge %0d: got %b expected %b", e, running, exp_run);
            end
        end
    endtask

    task automatic test_pause_resume();
        logic exp_en, exp_run;
        do_reset();
        for (int e = 0; e < 61; e++) begin
            btn_run  = (e <= 7) || (e >= 18 && e <= 21) || (e >= 40 && e <= 43);
            btn_step = (e >= 40 && e <= 43);
            @(posedge clk);
            #1;
            exp_en  = (e == 10) || (e == 14) || (e == 18) || (e == 22) ||
                      (e == 48) || (e == 52) || (e == 56) || (e == 60);
            exp_run = (e >= 7 && e <= 24) || (e >= 47);
            checks++;
            if (clk_en !== exp_en) begin
                failures++;
                $display("FAIL pause_resume clk_en edge %0d: got %b expected %b", e, clk_en, exp_en);
            end
            checks++;
            if (running !== exp_run) begin
                failures++;
                $display("FAIL pause_resume running edge %0d: got %b expected %b", e, running, exp_run);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic exp_en, exp_run;
        do_reset();
        for (int e = 0; e < 37; e++) begin
            rst     = (e == 16);
            btn_run = (e <= 3) || (e >= 20 && e <= 23);
            @(posedge clk);
            #1;
            exp_en  = (e == 10) || (e == 14) || (e == 30) || (e == 34);
            exp_run = (e >= 7 && e <= 15) || (e >= 27);
            checks++;
            if (clk_en !== exp_en) begin
                failures++;
                $display("FAIL reset_mid_run clk_en edge %0d: got %b expected %b", e, clk_en, exp_en);
            end
            checks++;
            if (running !== exp_run) begin
                failures++;
                $display("FAIL reset_mid_run running edge %0d: got %b expected %b", e, running, exp_run);
            end
        end
        rst = 1'b0;
    endtask
`else
    task automatic test_autorun();
        logic exp_en, exp_run;
        do_reset();
        checks++;
        if (running !== 1'b1 || clk_en !== 1'b0) begin
            failures++;
            $display("FAIL autorun after reset: got running=%b clk_en=%b expected 1 0", running, clk_en);
        end
        for (int e = 0; e < 36; e++) begin
            btn_run = (e >= 20 && e <= 23);
            @(posedge clk);
            #1;
            exp_en  = (e >= 3) && (e <= 23) && ((e - 3) % 4 == 0);
            exp_run = (e <= 26);
            checks++;
            if (clk_en !== exp_en) begin
                failures++;
                $display("FAIL autorun clk_en edge %0d: got %b expected %b", e, clk_en, exp_en);
            end
            checks++;
            if (running !== exp_run) begin
                failures++;
                $display("FAIL autorun running edge %0d: got %b expected %b", e, running, exp_run);
            end
        end
    endtask
`endif

    initial begin
`ifndef TICK_CTRL_AUTORUN_EN
        test_reset();
        test_run_hold();
        test_glitch();
        test_step();
        test_pause_resume();
        test_reset_mid_run();
`else
        test_autorun();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
